// File: rtl/rand_stat_monitor.sv
// Window statistics (sum, mean, min, max, histogram) over the 12-bit PRNG sample stream.
// Optional consecutive-repeat counter is built when RAND_STAT_REPEAT_EN is defined.
module rand_stat_monitor #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned WINDOW_LOG2 = 10,
  parameter int unsigned BUCKET_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sample_valid,
  input  logic [WIDTH-1:0]         sample,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH+WINDOW_LOG2-1:0] sum,
  output logic [WIDTH-1:0]         mean,
  output logic [WIDTH-1:0]         min_val,
  output logic [WIDTH-1:0]         max_val,
  input  logic [BUCKET_BITS-1:0]   hist_sel,
  output logic [WINDOW_LOG2:0]     hist_count,
  output logic [WINDOW_LOG2:0]     repeat_count
);

  localparam int unsigned SUM_W    = WIDTH + WINDOW_LOG2;
  localparam int unsigned CNT_W    = WINDOW_LOG2 + 1;
  localparam int unsigned NBUCKETS = 1 << BUCKET_BITS;

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_e;

  state_e                   state_q;
  logic                     busy_q;
  logic                     done_q;
  logic [SUM_W-1:0]         sum_q;
  logic [WIDTH-1:0]         min_q;
  logic [WIDTH-1:0]         max_q;
  logic [WINDOW_LOG2-1:0]   cnt_q;
  logic [CNT_W-1:0]         bucket_q [NBUCKETS];

  logic                     accept_c;
  logic [BUCKET_BITS-1:0]   bsel_c;

  assign accept_c = (state_q == ACCUM) && sample_valid;
  assign bsel_c   = sample[WIDTH-1 -: BUCKET_BITS];

  // Window FSM and accumulators; the counter wraps to zero on the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      for (int b = 0; b < NBUCKETS; b++) bucket_q[b] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sum_q   <= '0;
            min_q   <= '1;
            max_q   <= '0;
            cnt_q   <= '0;
            for (int b = 0; b < NBUCKETS; b++) bucket_q[b] <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            sum_q <= sum_q + SUM_W'(sample);
            if (sample < min_q) min_q <= sample;
            if (sample > max_q) max_q <= sample;
            bucket_q[bsel_c] <= bucket_q[bsel_c] + CNT_W'(1);
            cnt_q <= cnt_q + WINDOW_LOG2'(1);
            if (cnt_q == '1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= REPORT;
            end
          end
        end
        REPORT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sum        = sum_q;
  assign mean       = sum_q[SUM_W-1:WINDOW_LOG2];
  assign min_val    = min_q;
  assign max_val    = max_q;
  assign hist_count = bucket_q[hist_sel];

`ifdef RAND_STAT_REPEAT_EN
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] rep_q;

  // cnt_q == 0 marks the first sample of a window, which has no predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      rep_q  <= '0;
    end else if ((state_q == IDLE) && start) begin
      rep_q <= '0;
    end else if (accept_c) begin
      prev_q <= sample;
      if ((cnt_q != '0) && (sample == prev_q)) rep_q <= rep_q + CNT_W'(1);
    end
  end

  assign repeat_count = rep_q;
`else
  assign repeat_count = '0;
`endif

endmodule

// File: tb/tb_rand_stat_monitor.sv
// Scoreboard bench for rand_stat_monitor: stimulus pushes per-window expectations, monitor checks on done.
module tb_rand_stat_monitor;

  localparam int NS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sample_valid;
  logic [11:0] sample;
  logic        busy;
  logic        done;
  logic [21:0] sum;
  logic [11:0] mean;
  logic [11:0] min_val;
  logic [11:0] max_val;
  logic [2:0]  hist_sel;
  logic [10:0] hist_count;
  logic [10:0] repeat_count;

  rand_stat_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .sample(sample), .busy(busy), .done(done), .sum(sum), .mean(mean),
    .min_val(min_val), .max_val(max_val), .hist_sel(hist_sel),
    .hist_count(hist_count), .repeat_count(repeat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]     done_cyc;
    logic [21:0]     sum;
    logic [11:0]     mn;
    logic [11:0]     mx;
    logic [10:0]     rep;
    logic [7:0][10:0] hist;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   checked = 0;
  int   win[$];
  int   last_cyc;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: statistics derived directly from the list of accepted samples.
  function automatic exp_t model(input int dcyc);
    exp_t e;
    longint s = 0;
    int mn = 4095, mx = 0, rep = 0;
    int h[8];
    for (int b = 0; b < 8; b++) h[b] = 0;
    for (int i = 0; i < win.size(); i++) begin
      s += win[i];
      if (win[i] < mn) mn = win[i];
      if (win[i] > mx) mx = win[i];
      h[win[i] / 512]++;
      if (i > 0 && win[i] == win[i-1]) rep++;
    end
`ifndef RAND_STAT_REPEAT_EN
    rep = 0;
`endif
    e.done_cyc = 32'(dcyc);
    e.sum = 22'(s);
    e.mn  = 12'(mn);
    e.mx  = 12'(mx);
    e.rep = 11'(rep);
    for (int b = 0; b < 8; b++) e.hist[b] = 11'(h[b]);
    return e;
  endfunction

  function automatic int gen(input int kind, input int i);
    case (kind)
      0:       return 'h800;
      1:       return i % 4096;
      2:       return 'hFFF;
      4:       return 'h050;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  // Stimulus drives #1 after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    sample_valid = 1'b1;
    sample = 12'hABC;
    tick();
    start = 1'b0;
    sample_valid = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // gap: 0 none, 1 valid low every other cycle, 2 random idle cycles
  task automatic feed(input int n, input int kind, input int gap, input int start_at);
    for (int i = 0; i < n; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
        sample_valid = 1'b0;
        sample = 12'($urandom);
        tick();
      end
      sample = 12'(gen(kind, i));
      sample_valid = 1'b1;
      start = (i == start_at);
      last_cyc = cyc;
      win.push_back(int'(sample));
      tick();
    end
    sample_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_window(input int kind, input int gap, input int start_at);
    int budget;
    win.delete();
    do_start();
    feed(NS, kind, gap, start_at);
    exp_q.push_back(model(last_cyc + 1));
    pushed++;
    budget = 0;
    while (checked != pushed && budget < 100) begin
      tick();
      budget++;
    end
    check("window_checked_in_time", checked, pushed);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_mean"}, mean, 0);
    check({tag, "_min"}, min_val, 0);
    check({tag, "_max"}, max_val, 0);
    check({tag, "_rep"}, repeat_count, 0);
    check({tag, "_hist0"}, hist_count, 0);
  endtask

  // Monitor: pops one expectation per done pulse, then sweeps the histogram.
  initial begin
    hist_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", cyc, longint'(e.done_cyc));
          check("busy_at_done", busy, 0);
          check("sum", sum, e.sum);
          check("mean", mean, longint'(e.sum >> 10));
          check("min_val", min_val, e.mn);
          check("max_val", max_val, e.mx);
          check("repeat_count", repeat_count, e.rep);
          for (int b = 0; b < 8; b++) begin
            hist_sel = 3'(b);
            @(negedge clk);
            if (b == 0) check("done_one_cycle", done, 0);
            check($sformatf("hist%0d", b), hist_count, e.hist[b]);
          end
          hist_sel = 3'd0;
        end
        checked++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset");

    run_window(0, 0, -1);   // constant 0x800
    run_window(1, 0, -1);   // ramp
    run_window(1, 1, -1);   // ramp, valid every other cycle
    run_window(3, 2, 500);  // random with gaps, start pulsed mid-window

    // Abort mid-window, then feed samples without a start.
    win.delete();
    do_start();
    feed(300, 4, 0, -1);
    rst_n = 1'b0;
    #3;
    check_reset_outputs("abort");
    tick();
    rst_n = 1'b1;
    tick();
    feed(NS, 2, 0, -1);
    repeat (3) tick();
    check_reset_outputs("no_start");

    run_window(2, 0, -1);   // all 0xFFF
    run_window(3, 0, -1);
    run_window(3, 2, -1);

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
